tsc_ring_capture: RTL and testbench

Parametrised trigger/timestamp capture block. It continuously records DATA_W-bit samples into a DEPTH-entry ring buffer and timestamps the first trigger rising edge with a TS_W-bit cycle timer. After the trigger it captures POST_TRIG further samples, then freezes, so pre- and post-trigger history is both available. On request it streams the frozen buffer out serially, oldest sample first, to the host link.

---
 rtl/tsc_pkg.sv | 21 ++
 rtl/tsc_ring_buf.sv | 76 +++++++
 rtl/tsc_ring_capture.sv | 189 ++++++++++++++++++
 tb/tb_tsc_ring_capture.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/tsc_pkg.sv
// Shared definitions for the trigger/timestamp ring capture block.
// Contents: FSM state enum, default geometry and an elaboration helper
// used to validate the ring depth.
package tsc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_POST,
    ST_DONE,
    ST_SEND
  } tsc_state_e;

  localparam int unsigned TSC_DEPTH = 16;
  localparam int unsigned PTR_W     = $clog2(TSC_DEPTH);

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/tsc_ring_buf.sv
// DEPTH x DATA_W sample ring with write pointer, saturating fill counter and
// an oldest-first read pointer.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (memory not cleared)
//   clear        : restart capture, zero wr_ptr and fill
//   wr_en/wr_data: write one sample at wr_ptr, advance wr_ptr
//   rd_load      : present the oldest sample on rd_data, arm read pointer
//   rd_next      : present the next sample on rd_data, advance read pointer
//   rd_data      : combinational read data
//   fill         : number of valid entries, saturates at DEPTH
module tsc_ring_buf
  import tsc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = TSC_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_load,
  input  logic                       rd_next,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic [AW-1:0]     start_ptr;
  logic [AW-1:0]     rd_addr;

  // Once the ring has wrapped, the oldest entry is the one about to be
  // overwritten; before that the buffer starts at entry 0.
  assign start_ptr = (fill_q == CW'(DEPTH)) ? wr_ptr_q : '0;
  assign rd_addr   = rd_load ? start_ptr : rd_ptr_q;
  assign rd_data   = mem_q[rd_addr];
  assign fill      = fill_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (fill_q != CW'(DEPTH)) fill_d = fill_q + CW'(1);
    end
    if (rd_load)      rd_ptr_d = start_ptr + AW'(1);
    else if (rd_next) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/tsc_ring_capture.sv
// Trigger/timestamp capture: records samples into a ring, timestamps the
// first trigger rising edge, captures POST_TRIG more samples, freezes, and
// on request streams the frozen buffer out serially, oldest sample first,
// each sample MSB first.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : begin capture (IDLE or DONE)
//   trig       : trigger level, rising edge is the event
//   data       : sample input
//   send_buf   : stream frozen buffer (DONE only; start has priority)
//   ready      : high in IDLE and DONE
//   complete   : registered, high in DONE
//   trig_ts    : timer value at the trigger event
//   sd, sd_valid, sd_last : serial stream
module tsc_ring_capture
  import tsc_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = TSC_DEPTH,
  parameter int unsigned TS_W      = 32,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              trig,
  input  logic [DATA_W-1:0] data,
  input  logic              send_buf,
  output logic              ready,
  output logic              complete,
  output logic [TS_W-1:0]   trig_ts,
  output logic              sd,
  output logic              sd_valid,
  output logic              sd_last
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  if (!is_pow2(DEPTH)) begin : g_chk_depth
    $error("tsc_ring_capture: DEPTH must be a power of two >= 2");
  end
  if (POST_TRIG >= DEPTH) begin : g_chk_post
    $error("tsc_ring_capture: POST_TRIG must be less than DEPTH");
  end

  tsc_state_e        state_q, state_d;
  logic [TS_W-1:0]   timer_q, timer_d;
  logic [TS_W-1:0]   trig_ts_q, trig_ts_d;
  logic              trig_q, trig_d;
  logic              complete_q, complete_d;
  logic [AW-1:0]     post_cnt_q, post_cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CW-1:0]     samp_q, samp_d;
  logic              sd_valid_q, sd_valid_d;
  logic              sd_last_q, sd_last_d;

  logic              clear, wr_en, rd_load, rd_next;
  logic [DATA_W-1:0] rd_data;
  logic [CW-1:0]     fill;
  logic              trig_event;

  assign trig_event = trig && !trig_q;

  tsc_ring_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .wr_en   (wr_en),
    .wr_data (data),
    .rd_load (rd_load),
    .rd_next (rd_next),
    .rd_data (rd_data),
    .fill    (fill)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    trig_ts_d  = trig_ts_q;
    trig_d     = trig;
    post_cnt_d = post_cnt_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    samp_d     = samp_q;
    sd_valid_d = sd_valid_q;
    sd_last_d  = sd_last_q;
    clear      = 1'b0;
    wr_en      = 1'b0;
    rd_load    = 1'b0;
    rd_next    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUNNING;
          clear     = 1'b1;
          timer_d   = '0;
          trig_ts_d = '0;
        end else if (state_q == ST_DONE && send_buf) begin
          state_d    = ST_SEND;
          rd_load    = 1'b1;
          sh_d       = rd_data;
          bit_d      = '0;
          samp_d     = CW'(1);
          sd_valid_d = 1'b1;
          sd_last_d  = (bit_d == BW'(DATA_W - 1)) && (samp_d == fill);
        end
      end
      ST_RUNNING: begin
        wr_en   = 1'b1;
        timer_d = timer_q + TS_W'(1);
        if (trig_event) begin
          trig_ts_d  = timer_q;
          post_cnt_d = '0;
          state_d    = (POST_TRIG == 0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        wr_en   = 1'b1;
        timer_d = timer_q + TS_W'(1);
        if (post_cnt_q == AW'(POST_TRIG - 1)) state_d = ST_DONE;
        else                                  post_cnt_d = post_cnt_q + AW'(1);
      end
      ST_SEND: begin
        if (sd_last_q) begin
          state_d    = ST_DONE;
          sd_valid_d = 1'b0;
          sd_last_d  = 1'b0;
        end else begin
          if (bit_q == BW'(DATA_W - 1)) begin
            rd_next = 1'b1;
            sh_d    = rd_data;
            bit_d   = '0;
            samp_d  = samp_q + CW'(1);
          end else begin
            sh_d  = sh_q << 1;
            bit_d = bit_q + BW'(1);
          end
          sd_last_d = (bit_d == BW'(DATA_W - 1)) && (samp_d == fill);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    complete_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      trig_ts_q  <= '0;
      trig_q     <= 1'b0;
      complete_q <= 1'b0;
      post_cnt_q <= '0;
      sh_q       <= '0;
      bit_q      <= '0;
      samp_q     <= '0;
      sd_valid_q <= 1'b0;
      sd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      trig_ts_q  <= trig_ts_d;
      trig_q     <= trig_d;
      complete_q <= complete_d;
      post_cnt_q <= post_cnt_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      samp_q     <= samp_d;
      sd_valid_q <= sd_valid_d;
      sd_last_q  <= sd_last_d;
    end
  end

  assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign complete = complete_q;
  assign trig_ts  = trig_ts_q;
  assign sd       = sh_q[DATA_W-1] & sd_valid_q;
  assign sd_valid = sd_valid_q;
  assign sd_last  = sd_last_q;

endmodule

// File: tb/tb_tsc_ring_capture.sv
// Self-checking bench for tsc_ring_capture (DATA_W=8, DEPTH=8, POST_TRIG=3).
// A second instance with TS_W=8 shares the stimulus to exercise timer wrap.
// The reference model keeps every sample written since start in a queue;
// the expected stream is the newest min(count, DEPTH) samples, oldest first.
module tb_tsc_ring_capture;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int PT = 3;

  logic          clk = 1'b0;
  logic          reset, start, trig, send_buf;
  logic [DW-1:0] data;
  logic          ready, complete, sd, sd_valid, sd_last;
  logic [31:0]   trig_ts;
  logic          ready8, complete8, sd8, sd_valid8, sd_last8;
  logic [7:0]    trig_ts8;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] samples [$];

  always #5 clk = ~clk;

  tsc_ring_capture #(.DATA_W(DW), .DEPTH(DP), .TS_W(32), .POST_TRIG(PT)) u_dut (
    .clk(clk), .reset(reset), .start(start), .trig(trig), .data(data),
    .send_buf(send_buf), .ready(ready), .complete(complete), .trig_ts(trig_ts),
    .sd(sd), .sd_valid(sd_valid), .sd_last(sd_last)
  );

  tsc_ring_capture #(.DATA_W(DW), .DEPTH(DP), .TS_W(8), .POST_TRIG(PT)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .trig(trig), .data(data),
    .send_buf(send_buf), .ready(ready8), .complete(complete8), .trig_ts(trig_ts8),
    .sd(sd8), .sd_valid(sd_valid8), .sd_last(sd_last8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One capture: start pulse, then sample k is driven in the k-th RUNNING
  // cycle (timer == k). Trigger rises at k == t_at.
  task automatic capture(input int t_at, input bit rnd, input bit pre_high, input bit with_send);
    samples.delete();
    if (pre_high) begin
      trig = 1'b1;
      step();
      step();
    end
    start    = 1'b1;
    send_buf = with_send;
    step();
    start    = 1'b0;
    send_buf = 1'b0;
    chk("run_ready", {63'd0, ready}, 64'd0);
    chk("run_complete", {63'd0, complete}, 64'd0);
    chk("run_sd_valid", {62'd0, sd_valid, sd_valid8}, 64'd0);
    for (int k = 0; k <= t_at + PT; k++) begin
      data = rnd ? DW'($urandom) : DW'(k);
      if (pre_high) trig = (k < 5) || (k >= t_at);
      else          trig = (k == t_at) || (k == t_at + 2);
      samples.push_back(data);
      if (k == t_at + PT) chk("pre_done", {62'd0, complete, ready}, 64'd0);
      step();
      if (k == t_at) chk("trig_ts_early", 64'(trig_ts), 64'(t_at));
    end
    trig = 1'b0;
    chk("done_flags", {60'd0, ready, complete, ready8, complete8}, 64'hF);
    chk("trig_ts", 64'(trig_ts), 64'(t_at));
    chk("trig_ts8", 64'(trig_ts8), 64'(t_at % 256));
  endtask

  // Stream the frozen buffer and compare every bit against the model.
  // reset_after >= 0 asserts reset once that many bits have been seen.
  task automatic stream(input int reset_after);
    int n;
    int nbits;
    logic [DW-1:0] s;
    logic eb, el;
    n = (samples.size() < DP) ? samples.size() : DP;
    nbits = n * DW;
    send_buf = 1'b1;
    step();
    send_buf = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == reset_after) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_serial", {61'd0, sd, sd_valid, sd_last}, 64'd0);
        chk("rst_serial8", {61'd0, sd8, sd_valid8, sd_last8}, 64'd0);
        chk("rst_flags", {60'd0, ready, complete, ready8, complete8}, 64'hA);
        chk("rst_trig_ts", {24'd0, trig_ts8, trig_ts}, 64'd0);
        return;
      end
      s  = samples[samples.size() - n + i / DW];
      eb = s[DW - 1 - (i % DW)];
      el = (i == nbits - 1);
      chk("sd_bit", {60'd0, sd, sd_valid, sd_last, ready}, {60'd0, eb, 1'b1, el, 1'b0});
      chk("sd_bit8", {60'd0, sd8, sd_valid8, sd_last8, ready8}, {60'd0, eb, 1'b1, el, 1'b0});
      step();
    end
    chk("post_send", {60'd0, sd_valid, sd_last, ready, complete}, 64'h3);
    chk("post_send8", {60'd0, sd_valid8, sd_last8, ready8, complete8}, 64'h3);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; trig = 1'b0; send_buf = 1'b0; data = '0;
    step();
    step();
    reset = 1'b0;
    chk("reset_flags", {62'd0, ready, complete}, 64'h2);
    chk("reset_serial", {61'd0, sd, sd_valid, sd_last}, 64'd0);
    chk("reset_trig_ts", 64'(trig_ts), 64'd0);

    // send_buf and trig are ignored in IDLE
    send_buf = 1'b1;
    trig     = 1'b1;
    step();
    send_buf = 1'b0;
    trig     = 1'b0;
    step();
    chk("idle_ignore", {61'd0, sd_valid, ready, complete}, 64'h2);

    // Full buffer: expect 0x10..0x17
    capture(20, 1'b0, 1'b0, 1'b0);
    stream(-1);
    // Re-send gives the identical bitstream
    stream(-1);

    // Partial fill: 6 samples 0x00..0x05
    capture(2, 1'b0, 1'b0, 1'b0);
    stream(-1);

    // Trigger level held across start: event only at timer 9
    capture(9, 1'b0, 1'b1, 1'b0);
    stream(-1);

    // start beats send_buf in DONE
    capture(12, 1'b0, 1'b0, 1'b1);
    stream(-1);

    // Reset mid-stream after the 10th bit
    capture(6, 1'b1, 1'b0, 1'b0);
    stream(10);

    // Timer wrap on the 8-bit instance: 300 mod 256 = 44
    capture(300, 1'b0, 1'b0, 1'b0);
    stream(-1);

    // Random data and trigger positions, including trigger in the first cycle
    capture(0, 1'b1, 1'b0, 1'b0);
    stream(-1);
    for (int r = 0; r < 4; r++) begin
      capture(int'($urandom_range(1, 40)), 1'b1, 1'b0, 1'b0);
      stream(-1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
